// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared HI/LO op codes, FSM states and latency defaults
package mdu_pkg;

  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULTU = 4'd1,
    MD_MULT  = 4'd2,
    MD_DIVU  = 4'd3,
    MD_DIV   = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2
  } md_state_e;

  // Codes 9-15 decode as NONE, so only 1..8 count as a real HI/LO op.
  function automatic logic is_md_op(input logic [3:0] op);
    return (op >= 4'(MD_MULTU)) && (op <= 4'(MD_MFLO));
  endfunction

  function automatic logic is_xalu_op(input logic [3:0] op);
    return (op >= 4'(MD_MULTU)) && (op <= 4'(MD_DIV));
  endfunction

endpackage

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - HI/LO hazard controller: issues mult/div, stalls HI/LO users, rolls back on early flush
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ex_valid,
  input  logic [3:0] ex_md_op,
  input  logic       int_flush,
  input  logic       xalu_busy,
  output logic       xalu_start,
  output logic [1:0] xalu_op,
  output logic       xalu_we,
  output logic       xalu_hilo,
  output logic       xalu_clear,
  output logic       md_stall,
  output logic       hilo_sel
);

  localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYC - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYC - 1);

  md_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic             issued_d;

  logic       is_idle;
  logic       op_div;
  logic       op_mt;
  logic       issue;
  logic       mt_write;
  logic       flush_roll;
  logic [3:0] op_m1;

  always_comb begin
    is_idle    = (state == ST_IDLE);
    op_div     = (ex_md_op == 4'(MD_DIVU)) || (ex_md_op == 4'(MD_DIV));
    op_mt      = (ex_md_op == 4'(MD_MTHI)) || (ex_md_op == 4'(MD_MTLO));
    op_m1      = ex_md_op - 4'd1;
    issue      = !rst && is_idle && ex_valid && !int_flush && is_xalu_op(ex_md_op);
    mt_write   = !rst && is_idle && ex_valid && !int_flush && op_mt;
    // issued_d marks an issue not yet committed; a flush now undoes it.
    flush_roll = !rst && int_flush && issued_d;

    xalu_start = issue;
    xalu_op    = issue ? op_m1[1:0] : 2'b00;
    xalu_we    = mt_write;
    xalu_hilo  = mt_write && (ex_md_op == 4'(MD_MTHI));
    xalu_clear = flush_roll;
    md_stall   = !rst && ex_valid && !int_flush && is_md_op(ex_md_op) && !is_idle;
    hilo_sel   = !rst && (ex_md_op == 4'(MD_MFHI));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      issued_d <= 1'b0;
    end else begin
      issued_d <= issue;
      if (flush_roll) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (issue) begin
              state <= ST_RUN;
              cnt   <= op_div ? DIV_LOAD : MULT_LOAD;
            end
          end
          ST_RUN: begin
            // The cycle in which the counter steps to 0 decides IDLE vs WAIT.
            if (cnt > CNT_W'(1)) begin
              cnt <= cnt - CNT_W'(1);
            end else begin
              cnt   <= '0;
              state <= xalu_busy ? ST_WAIT : ST_IDLE;
            end
          end
          ST_WAIT: begin
            if (!xalu_busy) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
